// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core: sequences the shared datapath through
// fetch, decode, execute, memory and writeback, with a mem_req/mem_ready handshake.
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_write,
  output logic        adr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  imm_src,
  output logic [1:0]  result_src,
  output logic [2:0]  alu_cntrl,
  output logic        retire,
  output logic        trap,
  output logic [3:0]  state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC_R  = 4'd6,
    S_EXEC_I  = 4'd7,
    S_ALUWB   = 4'd8,
    S_BEQ     = 4'd9,
    S_JAL     = 4'd10,
    S_JALR    = 4'd11,
    S_JALR_PC = 4'd12,
    S_TRAP    = 4'd13
  } state_e;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  localparam logic [1:0] A_PC = 2'b00, A_OLDPC = 2'b01, A_RS1 = 2'b10;
  localparam logic [1:0] B_RS2 = 2'b00, B_IMM = 2'b01, B_FOUR = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_LIVE = 2'b10;
  localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR = 3'b011, ALU_SLT = 3'b101;

  state_e      state_q, state_d;
  logic        trap_q, trap_d;
  logic [2:0]  alu_dec;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        unused_instr_bits;

  assign opcode            = instr[6:0];
  assign funct3            = instr[14:12];
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign state             = state_q;
  assign trap              = trap_q;

  // funct7[5] only selects sub for register-register ops; addi with that bit set is still add
  always_comb begin
    alu_dec = ALU_ADD;
    case (funct3)
      3'b000:  if (opcode == OP_R && instr[30]) alu_dec = ALU_SUB;
      3'b010:  alu_dec = ALU_SLT;
      3'b110:  alu_dec = ALU_OR;
      3'b111:  alu_dec = ALU_AND;
      default: alu_dec = ALU_ADD;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = A_PC;
    alu_src_b  = B_RS2;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    alu_cntrl  = ALU_ADD;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = B_FOUR;
        result_src = RES_LIVE;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      // Speculatively form the branch target in alu_out while decoding
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_src   = IMM_B;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BEQ:            state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_src   = (opcode == OP_STORE) ? IMM_S : IMM_I;
        state_d   = (opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        retire    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_cntrl = alu_dec;
        state_d   = S_ALUWB;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_cntrl = alu_dec;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = A_RS1;
        alu_cntrl = ALU_SUB;
        pc_write  = zero;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      // Jumps load the PC here and reuse ALUWB to write the link address
      S_JAL, S_JALR_PC: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_FOUR;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        state_d   = S_JALR_PC;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    trap_d = trap_q | (state_d == S_TRAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= state_e'(RESET_STATE);
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: instructions expand into per-cycle expected
// output records; a negedge monitor pops and compares one record per DUT cycle.
module tb_multicycle_controller;

  logic        clk, rst, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, retire, trap;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_cntrl;
  logic [3:0]  state;

  typedef struct packed {
    logic [3:0] st;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] a, b, imm, res;
    logic [2:0] alu;
    logic       retire, trap;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  multicycle_controller dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_src(imm_src), .result_src(result_src),
    .alu_cntrl(alu_cntrl), .retire(retire), .trap(trap), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  function automatic logic [2:0] alu_model(input logic [31:0] ins);
    case (ins[14:12])
      3'b000:  return (ins[6:0] == OP_R && ins[30]) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Expected outputs for one cycle, straight from the per-state action table
  function automatic rec_t exp_rec(input logic [3:0] st, input logic [31:0] ins,
                                   input logic mr, input logic z);
    rec_t e;
    e = '0;
    e.st = st;
    case (st)
      4'd0:  begin e.mem_req = 1; e.b = 2; e.res = 2; e.ir_write = mr; e.pc_write = mr; end
      4'd1:  begin e.a = 1; e.b = 1; e.imm = 2; end
      4'd2:  begin e.a = 2; e.b = 1; e.imm = (ins[6:0] == OP_STORE) ? 2'd1 : 2'd0; end
      4'd3:  begin e.mem_req = 1; e.adr_src = 1; end
      4'd4:  begin e.res = 1; e.reg_write = 1; e.retire = 1; end
      4'd5:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; e.retire = mr; end
      4'd6:  begin e.a = 2; e.alu = alu_model(ins); end
      4'd7:  begin e.a = 2; e.b = 1; e.alu = alu_model(ins); end
      4'd8:  begin e.reg_write = 1; e.retire = 1; end
      4'd9:  begin e.a = 2; e.alu = 3'b001; e.pc_write = z; e.retire = 1; end
      4'd10: begin e.a = 1; e.b = 2; e.pc_write = 1; end
      4'd11: begin e.a = 2; e.b = 1; end
      4'd12: begin e.a = 1; e.b = 2; e.pc_write = 1; end
      4'd13: e.trap = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // One DUT cycle: drive inputs, push the expected record, advance past the edge
  task automatic step(input logic [3:0] st, input logic mr, input logic r, input int zf);
    mem_ready = mr;
    rst       = r;
    zero      = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
    exp_q.push_back(exp_rec(st, instr, mr, zero));
    @(posedge clk);
    #1;
  endtask

  function automatic logic rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expands an instruction into its state path; abort raises rst in the last memory wait
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input int zf, input bit abort, input int trap_cycles);
    instr = ins;
    for (int i = 0; i <= fw; i++) step(4'd0, (i == fw), 1'b0, zf);
    step(4'd1, rnd_bit(), 1'b0, zf);
    case (ins[6:0])
      OP_LOAD: begin
        step(4'd2, rnd_bit(), 1'b0, zf);
        if (abort) begin
          for (int i = 0; i < mw; i++) step(4'd3, 1'b0, 1'b0, zf);
          step(4'd3, 1'b0, 1'b1, zf);
        end else begin
          for (int i = 0; i <= mw; i++) step(4'd3, (i == mw), 1'b0, zf);
          step(4'd4, rnd_bit(), 1'b0, zf);
        end
      end
      OP_STORE: begin
        step(4'd2, rnd_bit(), 1'b0, zf);
        for (int i = 0; i <= mw; i++) step(4'd5, (i == mw), 1'b0, zf);
      end
      OP_R:    begin step(4'd6, rnd_bit(), 1'b0, zf); step(4'd8, rnd_bit(), 1'b0, zf); end
      OP_I:    begin step(4'd7, rnd_bit(), 1'b0, zf); step(4'd8, rnd_bit(), 1'b0, zf); end
      OP_BEQ:  step(4'd9, rnd_bit(), 1'b0, zf);
      OP_JAL:  begin step(4'd10, rnd_bit(), 1'b0, zf); step(4'd8, rnd_bit(), 1'b0, zf); end
      OP_JALR: begin
        step(4'd11, rnd_bit(), 1'b0, zf);
        step(4'd12, rnd_bit(), 1'b0, zf);
        step(4'd8, rnd_bit(), 1'b0, zf);
      end
      default: begin
        for (int i = 1; i < trap_cycles; i++) step(4'd13, rnd_bit(), 1'b0, zf);
        step(4'd13, rnd_bit(), 1'b1, zf);
      end
    endcase
  endtask

  function automatic bit is_legal(input logic [6:0] op);
    return op == OP_LOAD || op == OP_STORE || op == OP_R || op == OP_I ||
           op == OP_BEQ || op == OP_JAL || op == OP_JALR;
  endfunction

  // Monitor: every DUT cycle with an outstanding expectation is one comparison
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      rec_t e, o;
      e = exp_q.pop_front();
      o = '{st: state, mem_req: mem_req, mem_write: mem_write, adr_src: adr_src,
            ir_write: ir_write, pc_write: pc_write, reg_write: reg_write,
            a: alu_src_a, b: alu_src_b, imm: imm_src, res: result_src,
            alu: alu_cntrl, retire: retire, trap: trap};
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL cycle_outputs @%0d: got st=%0d vec=%h, expected st=%0d vec=%h",
                 cyc, o.st, o, e.st, e);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    int          k;
    rst = 1'b1; mem_ready = 1'b0; zero = 1'b0; instr = 32'h0;
    @(posedge clk); @(posedge clk); #1;

    run_instr(32'h0000A183, 0, 2, -1, 1'b1, 0);   // reset while MEMRD is stalled
    run_instr(32'h002081B3, 0, 0, -1, 1'b0, 0);   // add
    run_instr(32'h402081B3, 0, 0, -1, 1'b0, 0);   // sub
    run_instr(32'h00500093, 0, 0, -1, 1'b0, 0);   // addi
    run_instr(32'h0000A183, 0, 2, -1, 1'b0, 0);   // lw, two wait states
    run_instr(32'h0020A223, 1, 1, -1, 1'b0, 0);   // sw with fetch and store waits
    run_instr(32'h00208463, 0, 0, 1, 1'b0, 0);    // beq taken
    run_instr(32'h00208463, 0, 0, 0, 1'b0, 0);    // beq not taken
    run_instr(32'h008000EF, 0, 0, -1, 1'b0, 0);   // jal
    run_instr(32'h000080E7, 0, 0, -1, 1'b0, 0);   // jalr
    run_instr(32'h0000007F, 0, 0, -1, 1'b0, 10);  // illegal opcode, trap held

    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      k   = int'($urandom_range(0, 8));
      case (k)
        0, 8: op = OP_LOAD;
        1: op = OP_STORE;
        2: op = OP_R;
        3: op = OP_I;
        4: op = OP_BEQ;
        5: op = OP_JAL;
        6: op = OP_JALR;
        default: begin
          op = 7'h7F;
          for (int t = 0; t < 20; t++) begin
            op = 7'($urandom);
            if (!is_legal(op)) break;
          end
          if (is_legal(op)) op = 7'h7F;
        end
      endcase
      ins[6:0] = op;
      run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1,
                (k == 8), int'($urandom_range(1, 4)));
    end

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected cycles never observed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
